// File: rtl/mac_sequencer_if.sv
// MAC engine handshake: operand beats out of the sequencer, accumulated result back.
interface mac_sequencer_if #(
    parameter int unsigned DataBitWidth = 32
);
    logic                    mac_valid;
    logic                    mac_first;
    logic                    mac_last;
    logic [DataBitWidth-1:0] mac_a;
    logic [DataBitWidth-1:0] mac_b;
    logic                    mac_res_valid;
    logic [DataBitWidth-1:0] mac_res;

    modport master (
        output mac_valid, mac_first, mac_last, mac_a, mac_b,
        input  mac_res_valid, mac_res
    );

    modport slave (
        input  mac_valid, mac_first, mac_last, mac_a, mac_b,
        output mac_res_valid, mac_res
    );
endinterface

// File: rtl/mac_sequencer.sv
// Streams one 3x3 filter window through an external float MAC engine and
// stores each accumulated result into a linear result buffer, with a watchdog.
module mac_sequencer #(
    parameter int unsigned DataBitWidth     = 32,
    parameter int unsigned NumFilterCoeffs  = 9,
    parameter int unsigned ResultBufferSize = 24,
    parameter int unsigned MacEngineLatency = 5
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic                                  clear,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err_timeout,
    output logic [$clog2(NumFilterCoeffs)-1:0]    pix_addr,
    output logic [$clog2(NumFilterCoeffs)-1:0]    coeff_addr,
    input  logic [DataBitWidth-1:0]               pix_data,
    input  logic [DataBitWidth-1:0]               coeff_data,
    mac_sequencer_if.master                       mac,
    output logic                                  res_we,
    output logic [$clog2(ResultBufferSize)-1:0]   res_waddr,
    output logic [DataBitWidth-1:0]               res_wdata,
    output logic [$clog2(ResultBufferSize+1)-1:0] res_count,
    output logic                                  res_full
);
    localparam int unsigned AddrW   = $clog2(NumFilterCoeffs);
    localparam int unsigned PtrW    = $clog2(ResultBufferSize);
    localparam int unsigned CntW    = $clog2(ResultBufferSize + 1);
    localparam int unsigned WdLimit = 4 * MacEngineLatency + NumFilterCoeffs;
    localparam int unsigned WdW     = $clog2(WdLimit);

    localparam logic [AddrW-1:0] LastK   = AddrW'(NumFilterCoeffs - 1);
    localparam logic [WdW-1:0]   WdFire  = WdW'(WdLimit - 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(ResultBufferSize);

    typedef enum logic [1:0] {
        s_Idle,
        s_ReadInput,
        s_WaitForCalc,
        s_ReadResult
    } state_e;

    state_e                  state_q, state_d;
    logic [AddrW-1:0]        k_q, k_d;
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [WdW-1:0]          wd_q, wd_d;
    logic [DataBitWidth-1:0] result_q, result_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    logic                    mac_valid_q, mac_first_q, mac_last_q;
    logic                    full;

    assign full = (count_q == CntFull);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        wd_d     = wd_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;

        unique case (state_q)
            s_Idle: begin
                // clear takes priority over start when both arrive together
                if (clear) begin
                    count_d = '0;
                    wptr_d  = '0;
                    err_d   = 1'b0;
                end else if (start && !full) begin
                    state_d = s_ReadInput;
                    k_d     = '0;
                end
            end
            s_ReadInput: begin
                k_d = k_q + 1'b1;
                if (k_q == LastK) begin
                    state_d = s_WaitForCalc;
                    wd_d    = '0;
                end
            end
            s_WaitForCalc: begin
                if (mac.mac_res_valid) begin
                    result_d = mac.mac_res;
                    state_d  = s_ReadResult;
                    done_d   = 1'b1;
                end else if (wd_q == WdFire) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = s_Idle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            s_ReadResult: begin
                wptr_d  = wptr_q + 1'b1;
                count_d = count_q + 1'b1;
                state_d = s_Idle;
            end
            default: state_d = s_Idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= s_Idle;
            k_q         <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            wd_q        <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            result_q    <= result_d;
            err_q       <= err_d;
            done_q      <= done_d;
            // Beat flags trail the address by one cycle to line up with memory data
            mac_valid_q <= (state_q == s_ReadInput);
            mac_first_q <= (state_q == s_ReadInput) && (k_q == '0);
            mac_last_q  <= (state_q == s_ReadInput) && (k_q == LastK);
        end
    end

    assign busy        = (state_q != s_Idle);
    assign done        = done_q;
    assign err_timeout = err_q;

    assign pix_addr   = (state_q == s_ReadInput) ? k_q : '0;
    assign coeff_addr = (state_q == s_ReadInput) ? k_q : '0;

    assign mac.mac_valid = mac_valid_q;
    assign mac.mac_first = mac_first_q;
    assign mac.mac_last  = mac_last_q;
    assign mac.mac_a     = pix_data;
    assign mac.mac_b     = coeff_data;

    assign res_we    = (state_q == s_ReadResult);
    assign res_waddr = wptr_q;
    assign res_wdata = (state_q == s_ReadResult) ? result_q : '0;
    assign res_count = count_q;
    assign res_full  = full;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: memory and MAC engine models plus hand-computed expectations.
module tb_mac_sequencer;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic        clear;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [3:0]  pix_addr;
    logic [3:0]  coeff_addr;
    logic [31:0] pix_data;
    logic [31:0] coeff_data;
    logic        res_we;
    logic [4:0]  res_waddr;
    logic [31:0] res_wdata;
    logic [4:0]  res_count;
    logic        res_full;

    mac_sequencer_if #(.DataBitWidth(32)) mif ();

    mac_sequencer #(
        .DataBitWidth    (32),
        .NumFilterCoeffs (9),
        .ResultBufferSize(24),
        .MacEngineLatency(5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .clear      (clear),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .pix_addr   (pix_addr),
        .coeff_addr (coeff_addr),
        .pix_data   (pix_data),
        .coeff_data (coeff_data),
        .mac        (mif),
        .res_we     (res_we),
        .res_waddr  (res_waddr),
        .res_wdata  (res_wdata),
        .res_count  (res_count),
        .res_full   (res_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pix_mem   [0:15];
    logic [31:0] coeff_mem [0:15];

    always @(posedge clk) begin
        pix_data   <= pix_mem[pix_addr];
        coeff_data <= coeff_mem[coeff_addr];
    end

    // MAC engine model: answers five cycles after the mac_last beat
    logic        model_en;
    logic        stray;
    logic [31:0] model_res;
    int          cd;

    initial cd = 0;
    always @(posedge clk) begin
        if (model_en && mif.mac_valid && mif.mac_last) cd <= 5;
        else if (cd != 0)                              cd <= cd - 1;
    end

    assign mif.mac_res_valid = (model_en && cd == 1) || stray;
    assign mif.mac_res       = model_res;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    int          beats, writes, done_cnt, beat_err, first_beat, last_beat, done_cyc;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // Starts one operation at the current negedge and observes it until one cycle after done.
    task automatic run_op(input int mid_start);
        beats = 0; writes = 0; done_cnt = 0; beat_err = 0;
        first_beat = -1; last_beat = -1; done_cyc = -1;
        wr_addr = '0; wr_data = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            if (mif.mac_valid) begin
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                if (beats > 8) beat_err++;
                else if (mif.mac_a !== pix_mem[beats] || mif.mac_b !== coeff_mem[beats] ||
                         mif.mac_first !== 1'(beats == 0) || mif.mac_last !== 1'(beats == 8))
                    beat_err++;
                beats++;
            end else if (mif.mac_first || mif.mac_last) begin
                beat_err++;
            end
            if (res_we) begin
                writes++;
                wr_addr = res_waddr;
                wr_data = res_wdata;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = (cyc == mid_start);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset_n = 1'b0; start = 1'b0; clear = 1'b0;
        model_en = 1'b1; stray = 1'b0; model_res = 32'h4110_0000;
        for (int i = 0; i < 16; i++) begin
            pix_mem[i]   = 32'h3f80_0000;
            coeff_mem[i] = 32'h3f80_0000;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy",      32'(busy),          32'd0);
        check_eq("rst_done",      32'(done),          32'd0);
        check_eq("rst_err",       32'(err_timeout),   32'd0);
        check_eq("rst_count",     32'(res_count),     32'd0);
        check_eq("rst_full",      32'(res_full),      32'd0);
        check_eq("rst_mac_valid", 32'(mif.mac_valid), 32'd0);
        check_eq("rst_res_we",    32'(res_we),        32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single run with all-ones operands
        run_op(-1);
        check_eq("single_beats",    32'(beats),                  32'd9);
        check_eq("single_contig",   32'(last_beat - first_beat), 32'd8);
        check_eq("single_beat_err", 32'(beat_err),               32'd0);
        check_eq("single_writes",   32'(writes),                 32'd1);
        check_eq("single_waddr",    32'(wr_addr),                32'd0);
        check_eq("single_wdata",    wr_data,                     32'h4110_0000);
        check_eq("single_done",     32'(done_cnt),               32'd1);
        check_eq("single_count",    32'(res_count),              32'd1);
        check_eq("single_busy",     32'(busy),                   32'd0);

        // Distinct operands per address check the address/data alignment
        for (int i = 0; i < 9; i++) begin
            pix_mem[i]   = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
            coeff_mem[i] = 32'h2000_0000 + 32'(i) * 32'h0000_0303;
        end
        model_res = 32'h4200_0000;
        run_op(-1);
        check_eq("pat_beats",    32'(beats),     32'd9);
        check_eq("pat_beat_err", 32'(beat_err),  32'd0);
        check_eq("pat_waddr",    32'(wr_addr),   32'd1);
        check_eq("pat_wdata",    wr_data,        32'h4200_0000);
        check_eq("pat_count",    32'(res_count), 32'd2);

        // start and clear together in Idle: clear only
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check_eq("coll_busy",  32'(busy),      32'd0);
        check_eq("coll_count", 32'(res_count), 32'd0);
        @(negedge clk);
        check_eq("coll_busy2", 32'(busy),      32'd0);

        // Stray result strobe in Idle
        stray = 1'b1;
        @(negedge clk);
        check_eq("stray_we_same", 32'(res_we), 32'd0);
        stray = 1'b0;
        @(negedge clk);
        check_eq("stray_we_next", 32'(res_we),    32'd0);
        check_eq("stray_count",   32'(res_count), 32'd0);
        check_eq("stray_busy",    32'(busy),      32'd0);

        // start pulsed mid-sequence is ignored
        run_op(3);
        check_eq("mid_beats",  32'(beats),     32'd9);
        check_eq("mid_writes", 32'(writes),    32'd1);
        check_eq("mid_count",  32'(res_count), 32'd1);
        check_eq("mid_busy",   32'(busy),      32'd0);

        // Fill the buffer from empty
        pulse_clear();
        for (int r = 0; r < 24; r++) run_op(-1);
        check_eq("fill_last_waddr", 32'(wr_addr),   32'd23);
        check_eq("fill_count",      32'(res_count), 32'd24);
        check_eq("fill_full",       32'(res_full),  32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("full_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("full_start_busy2", 32'(busy),          32'd0);
        check_eq("full_start_valid", 32'(mif.mac_valid), 32'd0);
        check_eq("full_start_count", 32'(res_count),     32'd24);
        pulse_clear();
        check_eq("clr_count", 32'(res_count), 32'd0);
        check_eq("clr_full",  32'(res_full),  32'd0);

        // Watchdog
        run_op(-1);
        check_eq("pre_to_count", 32'(res_count), 32'd1);
        model_en = 1'b0;
        run_op(-1);
        check_eq("to_beats",   32'(beats),                 32'd9);
        check_eq("to_writes",  32'(writes),                32'd0);
        check_eq("to_done",    32'(done_cnt),              32'd1);
        check_eq("to_latency", 32'(done_cyc - last_beat),  32'd29);
        check_eq("to_err",     32'(err_timeout),           32'd1);
        check_eq("to_count",   32'(res_count),             32'd1);
        check_eq("to_busy",    32'(busy),                  32'd0);
        model_en = 1'b1;
        run_op(-1);
        check_eq("sticky_err",   32'(err_timeout), 32'd1);
        check_eq("sticky_count", 32'(res_count),   32'd2);
        pulse_clear();
        check_eq("clr_err",       32'(err_timeout), 32'd0);
        check_eq("clr_err_count", 32'(res_count),   32'd0);

        // Reset during beat k=4
        run_op(-1);
        begin
            int seen;
            bit hit;
            seen = 0;
            hit  = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
                if (mif.mac_valid) begin
                    if (seen == 4) hit = 1'b1;
                    seen++;
                end
                if (!hit) @(negedge clk);
            end
            check_eq("rmid_reached_k4", 32'(hit), 32'd1);
            reset_n = 1'b0;
            #1;
            check_eq("rmid_busy",  32'(busy),          32'd0);
            check_eq("rmid_valid", 32'(mif.mac_valid), 32'd0);
            check_eq("rmid_addr",  32'(pix_addr),      32'd0);
            check_eq("rmid_count", 32'(res_count),     32'd0);
            check_eq("rmid_we",    32'(res_we),        32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
        end
        run_op(-1);
        check_eq("post_rst_beats",    32'(beats),     32'd9);
        check_eq("post_rst_beat_err", 32'(beat_err),  32'd0);
        check_eq("post_rst_waddr",    32'(wr_addr),   32'd0);
        check_eq("post_rst_count",    32'(res_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DataBitWidth, default 32, float32 word width.
REQ-002 SHALL have parameter NumFilterCoeffs, default 9, products per result (3x3 filter).
REQ-003 SHALL have parameter ResultBufferSize, default 24, result buffer depth in words.
REQ-004 SHALL have parameter MacEngineLatency, default 5, nominal MAC latency in cycles, used by the watchdog only.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports start (input, 1, request one result) and clear (input, 1, empty the result buffer).
REQ-008 SHALL have ports busy (output, 1, not Idle), done (output, 1, one-cycle completion pulse) and err_timeout (output, 1, sticky watchdog flag).
REQ-009 SHALL have ports pix_addr and coeff_addr (outputs, 4 bits, index 0..8) and pix_data and coeff_data (inputs, 32 bits); the memories return data one cycle after the address.
REQ-010 SHALL have ports mac_valid, mac_first, mac_last (outputs, 1 each) and mac_a, mac_b (outputs, 32 bits) driving the float MAC engine.
REQ-011 SHALL have ports mac_res_valid (input, 1) and mac_res (input, 32): the MAC accumulated result.
REQ-012 SHALL have ports res_we (output, 1), res_waddr (output, 5), res_wdata (output, 32), res_count (output, 5) and res_full (output, 1).

Function
REQ-013 SHALL implement states s_Idle, s_ReadInput, s_WaitForCalc and s_ReadResult; busy = (state != s_Idle).
REQ-014 SHALL accept start only in s_Idle with res_full=0 and clear=0, moving to s_ReadInput on the next cycle; start in any other case SHALL be ignored.
REQ-015 SHALL, in s_ReadInput, drive pix_addr = coeff_addr = k for k = 0..8 on consecutive cycles, then enter s_WaitForCalc after k=8.
REQ-016 SHALL assert mac_valid, as a registered flag, in the cycle after each address, with mac_a = pix_data and mac_b = coeff_data passed through combinationally.
REQ-017 SHALL produce exactly 9 mac_valid beats per start, with no gaps.
REQ-018 SHALL assert mac_first only with the k=0 beat and mac_last only with the k=8 beat.
REQ-019 SHALL, in s_WaitForCalc, capture mac_res on the first mac_res_valid and move to s_ReadResult; mac_res_valid in any other state SHALL be ignored.
REQ-020 SHALL, in s_ReadResult (one cycle), assert res_we and done, with res_waddr = write pointer and res_wdata = the captured result.
REQ-021 SHALL, in that same s_ReadResult cycle, increment the write pointer and res_count, then return to s_Idle.
REQ-022 SHALL keep the write pointer linear (0..23) with no wrap; res_full = (res_count == ResultBufferSize).
REQ-023 SHALL, on clear in s_Idle, zero res_count and the write pointer next cycle and clear err_timeout; clear outside s_Idle SHALL be ignored; clear beats start in the same cycle.
REQ-024 SHALL run a watchdog in s_WaitForCalc: if no mac_res_valid arrives within 4*MacEngineLatency+NumFilterCoeffs cycles (29 by default), set err_timeout, write nothing, pulse done and return to s_Idle.
REQ-025 SHALL keep mac_* and res_we at 0 outside the beats and cycles defined above.

Reset
REQ-026 SHALL, while reset_n=0, immediately force state=s_Idle and zero every register and output: busy, done, err_timeout, all addresses, mac_valid/first/last, res_we, res_waddr, res_wdata, res_count, res_full; mac_a/mac_b follow their inputs.
REQ-027 SHALL abandon any in-flight operation on reset with no write, and SHALL resume after reset_n rises on the first clk edge.

Verification
REQ-028 Single run: pix = coeff = 0x3f800000 at all 9 addresses, MAC model returns 0x41100000 five cycles after mac_last -> 9 beats, then res_we at waddr 0 with wdata 0x41100000, done=1, res_count=1.
REQ-029 Fill: 24 back-to-back runs, then start -> 25th start ignored, busy stays 0, res_full=1, res_count=24; then clear -> res_count=0, res_full=0.
REQ-030 Timeout: MAC model never asserts mac_res_valid -> err_timeout=1 and done pulse 29 cycles after entering s_WaitForCalc, no res_we, res_count unchanged.
REQ-031 Collisions: start and clear high together in s_Idle -> clear only, busy stays 0; start pulsed in s_ReadInput -> still exactly 9 beats; stray mac_res_valid in s_Idle -> no write.
REQ-032 Reset mid-op: reset_n low during beat k=4 -> all outputs 0 at once, res_count=0; a new start after release -> full 9-beat sequence from k=0.
